// File: rtl/mul_div_sequencer.sv
// Purpose: 5-bit unsigned shift-add multiplier / restoring divider driving an external add/sub unit.
// Latency: start sampled at edge k, iterations at edges k+1..k+5, done pulses in the cycle after k+5.
// Backpressure: none; start is accepted only in IDLE, and start in RUN/DONE is dropped (not queued).
//
// Ports:
//   clk, rstN          - rising-edge clock, asynchronous active-low reset
//   start, op          - request strobe and operation (0 = multiply, 1 = divide)
//   opA, opB           - multiplicand/dividend and multiplier/divisor
//   busy, done         - busy in RUN and DONE; done is a one-cycle pulse in DONE
//   result             - mul: product; div: {remainder, quotient}; held until the next DONE
//   divByZero          - divide accepted with opB == 0; held alongside result
//   adderA/B/M         - operands and mode (1 = subtract) for the external adder
//   adderS, adderCout  - combinational sum and carry-out returned by the adder
module mul_div_sequencer #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               divByZero,
    output logic [WIDTH-1:0]   adderA,
    output logic [WIDTH-1:0]   adderB,
    output logic               adderM,
    input  logic [WIDTH-1:0]   adderS,
    input  logic               adderCout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [2:0]       cnt;
    logic             opR;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last_iter;

    assign last_iter = (cnt == 3'(WIDTH - 1));

    // Divide works on the partial remainder shifted left by one with the next
    // dividend bit brought in; hi[WIDTH-1] is the bit that falls off the top.
    assign r_shift = {hi[WIDTH-2:0], q[WIDTH-1]};

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: adder is only driven with live operands while iterating
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        adderA = '0;
        adderB = '0;
        adderM = 1'b0;
        case (state)
            RUN: begin
                busy   = 1'b1;
                adderA = opR ? r_shift : hi;
                adderB = d;
                adderM = opR;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration of the selected algorithm, using the adder's settled result
    always_comb begin
        hi_nxt = hi;
        q_nxt  = q;
        if (!opR) begin
            // Multiply: add d when the current multiplier LSB is set, then
            // shift the {carry, hi, q} chain right by one.
            if (q[0]) begin
                hi_nxt = {adderCout, adderS[WIDTH-1:1]};
                q_nxt  = {adderS[0], q[WIDTH-1:1]};
            end else begin
                hi_nxt = {1'b0, hi[WIDTH-1:1]};
                q_nxt  = {hi[0], q[WIDTH-1:1]};
            end
        end else begin
            // Divide: keep the difference when r' >= d. A set top bit means
            // r' >= 2^WIDTH > d, so the 5-bit difference is still exact.
            if (adderCout || hi[WIDTH-1]) begin
                hi_nxt = adderS;
                q_nxt  = {q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = r_shift;
                q_nxt  = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hi        <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            opR       <= 1'b0;
            result    <= '0;
            divByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hi        <= '0;
                        q         <= opA;
                        d         <= opB;
                        cnt       <= '0;
                        opR       <= op;
                        divByZero <= op && (opB == '0);
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 3'd1;
                    // Capture the final iteration directly so result is valid with done
                    if (last_iter) begin
                        result <= {hi_nxt, q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Purpose: self-checking bench for mul_div_sequencer with a combinational 5-bit add/sub unit.
// Latency: checks done exactly 6 cycles after the start edge and busy for 6 cycles.
// Backpressure: exercises ignored start during RUN/DONE and asynchronous abort by reset.
module tb_mul_div_sequencer;

    logic       clk;
    logic       rstN;
    logic       start;
    logic       op;
    logic [4:0] opA;
    logic [4:0] opB;
    logic       busy;
    logic       done;
    logic [9:0] result;
    logic       divByZero;
    logic [4:0] adderA;
    logic [4:0] adderB;
    logic       adderM;
    logic [4:0] adderS;
    logic       adderCout;

    int checks;
    int failures;

    mul_div_sequencer #(.WIDTH(5)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .op        (op),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .divByZero (divByZero),
        .adderA    (adderA),
        .adderB    (adderB),
        .adderM    (adderM),
        .adderS    (adderS),
        .adderCout (adderCout)
    );

    // External ripple adder: subtract is a + ~b + 1, carry-out 1 means no borrow
    logic [5:0] add_sum;
    always_comb begin
        add_sum = '0;
        if (adderM) begin
            add_sum = {1'b0, adderA} + {1'b0, ~adderB} + 6'd1;
        end else begin
            add_sum = {1'b0, adderA} + {1'b0, adderB};
        end
    end
    assign adderS    = add_sum[4:0];
    assign adderCout = add_sum[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model: plain arithmetic from the operation definition
    function automatic logic [10:0] ref_op(input logic o, input logic [4:0] a, input logic [4:0] b);
        int prod;
        int quo;
        int rem;
        if (!o) begin
            prod = int'(a) * int'(b);
            return {1'b0, 10'(prod)};
        end
        if (b == 5'd0) begin
            return {1'b1, a, 5'd31};
        end
        quo = int'(a) / int'(b);
        rem = int'(a) % int'(b);
        return {1'b0, 5'(rem), 5'(quo)};
    endfunction

    // Issue one operation and follow it for 8 cycles after the start edge.
    // inject pulses start with junk operands in cycles 2 and 6, which must be ignored.
    task automatic run_op(input logic o, input logic [4:0] a, input logic [4:0] b, input bit inject);
        logic [10:0] exp;
        exp = ref_op(o, a, b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        opA   = 5'($urandom_range(0, 31));
        opB   = 5'($urandom_range(0, 31));
        op    = 1'($urandom_range(0, 1));
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check_val($sformatf("done_c%0d", i), 32'(done), 32'(i == 6));
            check_val($sformatf("busy_c%0d", i), 32'(busy), 32'(i <= 6));
            if (i <= 5) begin
                check_val($sformatf("adderM_c%0d", i), 32'(adderM), 32'(o));
            end
            if (i >= 6) begin
                check_val($sformatf("result_c%0d", i), 32'(result), 32'(exp[9:0]));
                check_val($sformatf("dbz_c%0d", i), 32'(divByZero), 32'(exp[10]));
            end
            if (inject) begin
                if (i == 2 || i == 6) begin
                    start = 1'b1;
                    op    = 1'($urandom_range(0, 1));
                    opA   = 5'($urandom_range(0, 31));
                    opB   = 5'($urandom_range(0, 31));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int done_seen;
        checks    = 0;
        failures  = 0;
        rstN      = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        opA       = '0;
        opB       = '0;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        check_val("rst_dbz", 32'(divByZero), 32'd0);
        check_val("rst_adder", {21'd0, adderM, adderA, adderB}, 32'd0);
        rstN = 1'b1;

        // Directed cases
        run_op(1'b0, 5'd31, 5'd31, 1'b0);
        run_op(1'b0, 5'd0,  5'd17, 1'b0);
        run_op(1'b0, 5'd1,  5'd1,  1'b0);
        run_op(1'b1, 5'd29, 5'd5,  1'b0);
        run_op(1'b1, 5'd31, 5'd1,  1'b0);
        run_op(1'b1, 5'd3,  5'd7,  1'b0);
        run_op(1'b1, 5'd13, 5'd0,  1'b0);
        run_op(1'b0, 5'd2,  5'd3,  1'b0);
        run_op(1'b0, 5'd9,  5'd9,  1'b1);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        opA   = 5'd27;
        opB   = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("pre_abort_busy", 32'(busy), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_result", 32'(result), 32'd0);
        check_val("abort_dbz", 32'(divByZero), 32'd0);
        check_val("abort_adder", {21'd0, adderM, adderA, adderB}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_val("abort_no_done", 32'(done_seen), 32'd0);
        run_op(1'b1, 5'd27, 5'd4, 1'b0);

        // Randomized operations, divisor zero forced in a fraction of divides
        for (int n = 0; n < 40; n++) begin
            logic       ro;
            logic [4:0] ra;
            logic [4:0] rb;
            ro = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            run_op(ro, ra, rb, (n % 8) == 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Multi-cycle 5-bit unsigned multiply/divide controller that sits directly upstream and downstream of the 5-bit add/subtract unit.
- Drives the adder's A, B and mode (m) inputs from its internal registers, then captures the sum and carry-out on each clock.
- Runs a shift-add multiply or a restoring divide, one iteration per cycle, and presents a registered 10-bit result with a done pulse.

Parameters:
- WIDTH, 5, operand width. Must equal the adder width; only 5 is supported and verified.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide; sampled with start
- opA  in  5  multiplicand / dividend
- opB  in  5  multiplier / divisor
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse in DONE
- result  out  10  mul: product[9:0]; div: {remainder[4:0], quotient[4:0]}
- divByZero  out  1  set when a divide with opB==0 is accepted; held with result
- adderA  out  5  to adder a4..a0
- adderB  out  5  to adder b4..b0
- adderM  out  1  to adder m (0 = add, 1 = subtract)
- adderS  in  5  from adder s4..s0
- adderCout  in  1  from adder carryOut

Behaviour:
- Reset (async, rstN=0): state=IDLE; all registers, result, done, busy and divByZero go to 0. adderA/adderB/adderM are 0 during reset.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Internal registers: hi[4:0], q[4:0], d[4:0] (operand B copy), cnt[2:0], opR.
- States:
  - IDLE: busy=0. When start=1:
    - hi←0, q←opA, d←opB, cnt←0, opR←op.
    - divByZero←(op & opB==0).
    - Go to RUN.
  - RUN: one iteration per cycle; cnt increments. After the iteration at cnt==4, go to DONE.
  - DONE: result←{hi,q}; done=1 for exactly this cycle; next state is IDLE.
- result is held until the next operation's DONE. start in RUN or DONE is ignored (not queued).
- Latency: start sampled at edge k; RUN iterations at edges k+1..k+5; done high in the cycle after edge k+5; result valid from that same cycle.
- Adder drive (combinational from registers):
  - IDLE/DONE: adderA=0, adderB=0, adderM=0.
  - RUN multiply: adderA=hi, adderB=d, adderM=0.
  - RUN divide: adderA=r' where r'={hi[3:0],q[4]}, adderB=d, adderM=1.
- Multiply iteration:
  - If q[0]=1: hi←{adderCout, adderS[4:1]}, q←{adderS[0], q[4:1]}.
  - Else: hi←{0, hi[4:1]}, q←{hi[0], q[4:1]}.
  - After 5 iterations, {hi,q} = opA×opB. Result is exact with no overflow, max 31×31=961.
- Divide iteration (restoring), with top=hi[4]:
  - If (adderCout | top): hi←adderS, q←{q[3:0],1}.
  - Else: hi←r', q←{q[3:0],0}.
  - top=1 means r'≥32>d, so the subtract always succeeds and the 5-bit difference is exact.
  - End state: q=quotient, hi=remainder.
- Divide by zero is not special-cased in the datapath. Subtracting 0 always yields carry 1, giving quotient=31 and remainder=dividend; divByZero=1 flags it.
- The adder is purely combinational: adderS/adderCout must settle within the same cycle as adderA/adderB/adderM. No extra adder pipeline stage is allowed.

Test Plan:
- Multiply, opA=31, opB=31 -> result=961 (0x3C1), divByZero=0; done exactly 6 cycles after the start edge, one cycle wide; busy high 6 cycles.
- Multiply, opA=0, opB=17 -> result=0; also 1×1 -> result=1; adderM=0 throughout RUN.
- Divide, opA=29, opB=5 -> quotient=5, remainder=4, result=133; adderM=1 throughout RUN.
- Divide, opA=31, opB=1 -> quotient=31, remainder=0. Divide, opA=3, opB=7 -> quotient=0, remainder=3.
- Divide by zero, opA=13, opB=0 -> quotient=31, remainder=13, divByZero=1. A following multiply 2×3 -> result=6, divByZero=0.
- start pulsed with new operands in cycles 2 and 6 of a 9×9 multiply -> both ignored, result=81. Then rstN=0 asynchronously during RUN of a new divide -> all outputs 0 immediately, no done pulse; next start completes normally.
